// File: rtl/frv_gf256_aff_seq.sv
// frv_gf256_aff: single-byte GF(2^8) affine core, r = M*b.
//   b : input byte
//   m : 64-bit matrix, column j = m[8j+7:8j], XORed into r when b[j] = 1
//   r : transformed byte (without the affine constant)
//
// frv_gf256_aff_seq: multi-cycle unit applying b' = M*b ^ c to each byte of
// a 32-bit operand, one byte per cycle through a shared frv_gf256_aff.
//   g_clk, g_reset        : clock, synchronous active-high reset
//   flush                 : abandons any operation in flight
//   cfg_valid/hi/data     : matrix half-write (lo = m[31:0], hi = m[63:32]), IDLE only
//   op_valid/ready/rs1/imm: operation request handshake, operand and constant c
//   res_valid/ready/data  : result handshake and registered result word
//   busy                  : unit not IDLE
module frv_gf256_aff (
  input  logic [7:0]  b,
  input  logic [63:0] m,
  output logic [7:0]  r
);

  always_comb begin
    r = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      if (b[j]) r = r ^ m[8*j +: 8];
    end
  end

endmodule

module frv_gf256_aff_seq (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        cfg_valid,
  input  logic        cfg_hi,
  input  logic [31:0] cfg_data,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_rs1,
  input  logic [7:0]  op_imm,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] mat;
  logic [31:0] rs1_q;
  logic [7:0]  imm_q;
  logic [1:0]  idx;
  logic [31:0] res_q;
  logic [7:0]  byte_in;
  logic [7:0]  byte_aff;
  logic        accept;
  logic        cfg_we;

  assign op_ready  = (state == IDLE) && !flush;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_data  = res_q;
  assign accept    = op_valid && op_ready;
  // Matrix writes share the IDLE/no-flush qualifier with op acceptance, so an
  // op accepted on the same edge sees the updated matrix once RUN starts.
  assign cfg_we    = cfg_valid && (state == IDLE) && !flush;

  always_comb begin
    byte_in = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (idx == i[1:0]) byte_in = rs1_q[8*i +: 8];
    end
  end

  frv_gf256_aff u_aff (
    .b (byte_in),
    .m (mat),
    .r (byte_aff)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (idx == 2'd3) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= IDLE;
      mat   <= '0;
      rs1_q <= '0;
      imm_q <= '0;
      idx   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_we) begin
        if (cfg_hi) mat[63:32] <= cfg_data;
        else        mat[31:0]  <= cfg_data;
      end
      if (flush) begin
        rs1_q <= '0;
        imm_q <= '0;
        idx   <= '0;
      end else if (accept) begin
        rs1_q <= op_rs1;
        imm_q <= op_imm;
        idx   <= '0;
        res_q <= '0;
      end else if (state == RUN) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (idx == i[1:0]) res_q[8*i +: 8] <= byte_aff ^ imm_q;
        end
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_frv_gf256_aff_seq.sv
module tb_frv_gf256_aff_seq;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        flush;
  logic        cfg_valid;
  logic        cfg_hi;
  logic [31:0] cfg_data;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_rs1;
  logic [7:0]  op_imm;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] ID_LO  = 32'h08040201;
  localparam logic [31:0] ID_HI  = 32'h80402010;
  localparam logic [31:0] AES_LO = 32'hF87C3E1F;
  localparam logic [31:0] AES_HI = 32'h8FC7E3F1;

  frv_gf256_aff_seq dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .flush     (flush),
    .cfg_valid (cfg_valid),
    .cfg_hi    (cfg_hi),
    .cfg_data  (cfg_data),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_rs1    (op_rs1),
    .op_imm    (op_imm),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Row-wise model: output bit k is the parity of row k of M masked by b.
  function automatic logic [31:0] model_word(input logic [31:0] w, input logic [7:0] c,
                                             input logic [63:0] m);
    logic [31:0] r;
    logic [7:0]  b;
    logic        p;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      for (int k = 0; k < 8; k++) begin
        p = 1'b0;
        for (int j = 0; j < 8; j++) p = p ^ (m[8*j+k] & b[j]);
        r[8*i+k] = p ^ c[k];
      end
    end
    return r;
  endfunction

  // Cycle model + scoreboard, evaluated on pre-edge values.
  int          mdl_st = 0;   // 0 idle, 1..4 run, 5 done
  logic [63:0] mdl_m  = '0;
  logic [63:0] nm;
  logic [31:0] exp_q[$];

  always @(posedge g_clk) begin
    if (!g_reset) begin
      chk("op_ready", {31'd0, op_ready}, {31'd0, (mdl_st == 0) && !flush});
      chk("res_valid", {31'd0, res_valid}, {31'd0, mdl_st == 5});
      chk("busy", {31'd0, busy}, {31'd0, mdl_st != 0});
      if (mdl_st == 5) begin
        if (exp_q.size() != 0) chk("sb_data", res_data, exp_q[0]);
        else chk("sb_empty", 32'(exp_q.size()), 32'd1);
      end
    end
    if (g_reset) begin
      mdl_st <= 0;
      mdl_m  <= '0;
      exp_q.delete();
    end else if (flush) begin
      mdl_st <= 0;
      exp_q.delete();
    end else begin
      case (mdl_st)
        0: begin
          nm = mdl_m;
          if (cfg_valid) begin
            if (cfg_hi) nm[63:32] = cfg_data;
            else        nm[31:0]  = cfg_data;
          end
          mdl_m <= nm;
          if (op_valid) begin
            exp_q.push_back(model_word(op_rs1, op_imm, nm));
            mdl_st <= 1;
          end
        end
        5: if (res_ready) begin
          void'(exp_q.pop_front());
          mdl_st <= 0;
        end
        default: mdl_st <= mdl_st + 1;
      endcase
    end
  end

  task automatic cfg_write(input logic hi, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_hi    = hi;
    cfg_data  = d;
    @(negedge g_clk);
    cfg_valid = 1'b0;
  endtask

  // Drives one op (any cfg inputs already set ride along), waits for res_valid.
  task automatic run_op(input string tag, input logic [31:0] rs1, input logic [7:0] imm,
                        input logic [31:0] exp, input logic rr);
    int n;
    op_rs1    = rs1;
    op_imm    = imm;
    op_valid  = 1'b1;
    res_ready = rr;
    @(negedge g_clk);
    op_valid  = 1'b0;
    cfg_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 20) begin
      @(negedge g_clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd5);
    chk(tag, res_data, exp);
    if (rr) begin
      @(negedge g_clk);
      chk({tag, "_rdy"}, {31'd0, op_ready}, 32'd1);
    end
  endtask

  initial begin
    g_reset   = 1'b1;
    flush     = 1'b0;
    cfg_valid = 1'b0;
    cfg_hi    = 1'b0;
    cfg_data  = '0;
    op_valid  = 1'b0;
    op_rs1    = '0;
    op_imm    = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge g_clk);
    g_reset = 1'b0;
    chk("rst_data", res_data, 32'h0);
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Identity matrix
    cfg_write(1'b0, ID_LO);
    cfg_write(1'b1, ID_HI);
    run_op("ident", 32'hDEADBEEF, 8'h00, 32'hDEADBEEF, 1'b1);

    // AES affine
    cfg_write(1'b0, AES_LO);
    cfg_write(1'b1, AES_HI);
    run_op("aes", 32'h00000201, 8'h63, 32'h63635D7C, 1'b1);

    // Backpressure with an ignored cfg write in DONE
    run_op("bp", 32'h00000201, 8'h63, 32'h63635D7C, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        cfg_valid = 1'b1;
        cfg_hi    = 1'b0;
        cfg_data  = 32'h0;
      end else begin
        cfg_valid = 1'b0;
      end
      @(negedge g_clk);
      chk("bp_hold", res_data, 32'h63635D7C);
      chk("bp_ready", {31'd0, op_ready}, 32'd0);
    end
    cfg_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge g_clk);
    chk("bp_rel_ready", {31'd0, op_ready}, 32'd1);
    chk("bp_rel_valid", {31'd0, res_valid}, 32'd0);
    run_op("bp_rerun", 32'h00000201, 8'h63, 32'h63635D7C, 1'b1);

    // Simultaneous cfg hi write and op in IDLE
    cfg_write(1'b0, ID_LO);
    cfg_write(1'b1, ID_HI);
    cfg_write(1'b0, AES_LO);
    cfg_valid = 1'b1;
    cfg_hi    = 1'b1;
    cfg_data  = AES_HI;
    run_op("simul", 32'h00000201, 8'h63, 32'h63635D7C, 1'b1);

    // Flush at third RUN cycle, with competing op and cfg requests
    cfg_write(1'b0, ID_LO);
    cfg_write(1'b1, ID_HI);
    op_rs1   = 32'hCAFEF00D;
    op_imm   = 8'h00;
    op_valid = 1'b1;
    @(negedge g_clk);
    op_valid = 1'b0;
    repeat (2) @(negedge g_clk);
    flush     = 1'b1;
    op_valid  = 1'b1;
    cfg_valid = 1'b1;
    cfg_hi    = 1'b0;
    cfg_data  = 32'h0;
    @(negedge g_clk);
    flush     = 1'b0;
    op_valid  = 1'b0;
    cfg_valid = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk("fl_valid", {31'd0, res_valid}, 32'd0);
    repeat (8) @(negedge g_clk);
    run_op("fl_ident", 32'h01234567, 8'h00, 32'h01234567, 1'b1);

    // Reset in DONE
    run_op("pre_rst", 32'h11223344, 8'h00, 32'h11223344, 1'b0);
    g_reset = 1'b1;
    @(negedge g_clk);
    g_reset = 1'b0;
    res_ready = 1'b1;
    chk("rst2_valid", {31'd0, res_valid}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    chk("rst2_data", res_data, 32'h0);
    run_op("zero_m", 32'h12345678, 8'h5A, 32'h5A5A5A5A, 1'b1);

    repeat (2) @(negedge g_clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
